// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
// Imported by seq_div.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Iteration counter width for a given operand width (never below 1 bit).
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/add_sub.sv
// Datapath adder/subtractor: result = a + b, or a - b when sign is set.
// Reused by the divider for its trial subtraction.
module add_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    // Subtraction as a + ~b + 1 so one adder serves both operations.
    always_comb begin
        result = a + (sign ? ~b : b) + {{(WIDTH-1){1'b0}}, sign};
    end

endmodule

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Valid/ready on both the operand and result sides.
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    div_state_t state;
    div_state_t state_next;

    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] shift_q;
    // Partial remainder: the WIDTH+1-bit working value always has a zero
    // top bit after each step (it is < divisor), so only the low bits persist.
    logic [WIDTH-1:0] prem_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   prem_next;
    logic             qbit;
    logic             last;

    assign shifted = {prem_q, shift_q[WIDTH-1]};

    add_sub #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a      (shifted),
        .b      ({1'b0, divisor_q}),
        .sign   (1'b1),
        .result (trial)
    );

    assign qbit      = ~trial[WIDTH];
    assign prem_next = qbit ? trial : shifted;
    assign last      = (cnt_q == LAST_CNT);

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept, iterate WIDTH times, hold until handoff.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, shift/subtract iteration and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            divisor_q <= '0;
            shift_q   <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_q <= divisor;
                        shift_q   <= dividend;
                        prem_q    <= '0;
                        cnt_q     <= '0;
                        // Divide by zero short-circuits straight to a result.
                        if (divisor == '0) begin
                            quot_q <= '1;
                            rem_q  <= dividend;
                            dbz_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    shift_q <= {shift_q[WIDTH-2:0], qbit};
                    prem_q  <= prem_next[WIDTH-1:0];
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        quot_q <= {shift_q[WIDTH-2:0], qbit};
                        rem_q  <= prem_next[WIDTH-1:0];
                        dbz_q  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH=32).
// Checks latency, corner values, backpressure, reset and random pairs.
module tb_seq_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests    = 0;
    int fails    = 0;
    int accepts  = 0;
    int results  = 0;

    seq_div #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [31:0] a,
                         input logic [31:0] b);
        chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        accepts++;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q,
                           input logic [31:0] r, input logic z,
                           input int lat, input int stall);
        int n;
        start(tag, a, b);
        wait_done(n);
        chk({tag, " latency"}, 32'(n), 32'(lat));
        chk({tag, " quotient"}, quotient, q);
        chk({tag, " remainder"}, remainder, r);
        chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(z));
        repeat (stall) tick();
        chk({tag, " held quotient"}, quotient, q);
        if (out_valid) results++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
        chk({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eq;
        logic [31:0] er;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_by_zero", 32'(div_by_zero), 32'd0);

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 32, 0);
        run_div("div0", 32'h0000_1234, 32'd0, 32'hFFFF_FFFF,
                32'h0000_1234, 1'b1, 0, 0);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
                32'd0, 1'b0, 32, 0);
        run_div("5/9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 32, 0);
        run_div("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
                32'd0, 1'b0, 32, 0);

        // Backpressure: result must hold while out_ready is low.
        start("bp", 32'd1000, 32'd3);
        wait_done(n);
        chk("bp latency", 32'(n), 32'd32);
        results++;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = $urandom;
            divisor  = $urandom;
            tick();
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp quotient", quotient, 32'd333);
            chk("bp remainder", remainder, 32'd1);
            chk("bp div_by_zero", 32'(div_by_zero), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp in_ready after", 32'(in_ready), 32'd1);
        chk("bp out_valid after", 32'(out_valid), 32'd0);
        chk("bp quotient kept", quotient, 32'd333);
        chk("bp remainder kept", remainder, 32'd1);

        // Reset in the 10th RUN cycle discards the operation.
        start("rst", 32'hDEAD_BEEF, 32'd3);
        accepts--;
        repeat (9) tick();
        chk("rst still busy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst quotient", quotient, 32'd0);
        chk("rst remainder", remainder, 32'd0);
        run_div("1000/10", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 32, 0);

        // Random pairs with random result stalls against an arithmetic model.
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 7 == 3) b = '0;
            if (b == '0) begin
                eq = 32'hFFFF_FFFF;
                er = a;
            end else begin
                eq = a / b;
                er = a % b;
            end
            run_div($sformatf("rand%0d", i), a, b, eq, er, (b == '0),
                    (b == '0) ? 0 : 32, int'($urandom_range(0, 3)));
        end

        chk("results equal accepts", 32'(results), 32'(accepts));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
